// File: rtl/alu_risc_pkg.sv
// Shared definitions for the multi-cycle RISC ALU.
// Holds the 4-bit opcode map (including the codes reserved for RD/WR/BR/BRZ,
// which this block treats as "result 0, flags 0") and the FSM state encoding.
package alu_risc_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_RD  = 4'b0101;
  localparam logic [3:0] OP_WR  = 4'b0110;
  localparam logic [3:0] OP_BR  = 4'b0111;
  localparam logic [3:0] OP_BRZ = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_risc_mul_seq.sv
// Sequential unsigned shift-add multiplier.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (discards any partial product)
//   start      - load operands a/b; the first partial product is formed on this edge
//   a, b       - operands (only sampled when start is high)
//   busy       - steps still outstanding
//   done       - one-cycle pulse; product is final while done is high
//   product    - 2*DATAWIDTH-bit result
// Bit 0 of the multiplier is consumed on the start edge, the remaining
// DATAWIDTH-1 bits on the following edges, so done is high in the cycle after
// the last step and the caller can register the result on the next edge.
module alu_risc_mul_seq #(
  parameter int DATAWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATAWIDTH-1:0]   a,
  input  logic [DATAWIDTH-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [2*DATAWIDTH-1:0] product
);

  localparam int CW = $clog2(DATAWIDTH) + 1;

  logic [2*DATAWIDTH-1:0] acc_q;
  logic [2*DATAWIDTH-1:0] mcand_q;
  logic [DATAWIDTH-1:0]   mplier_q;
  logic [CW-1:0]          cnt_q;
  logic                   done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q    <= a[0] ? {{DATAWIDTH{1'b0}}, b} : '0;
        mcand_q  <= {{DATAWIDTH{1'b0}}, b} << 1;
        mplier_q <= a >> 1;
        cnt_q    <= CW'(DATAWIDTH - 1);
      end else if (cnt_q != '0) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = (cnt_q != '0);
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_risc_mc.sv
// Multi-cycle RISC ALU with registered result/flags and valid/ready on both sides.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake (select, data_1, data_2)
//   out_valid / out_ready - result handshake (alu_out and flags)
//   alu_out               - registered result
//   alu_zero_flag, alu_neg_flag - derived from the registered alu_out
//   alu_carry_flag, alu_ovf_flag - registered with the result
//   dbg_state             - current FSM state (alu_risc_pkg::state_e encoding)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The requester holds in_valid and its payload until in_ready is seen;
// the block holds out_valid and the result stable until out_ready is seen.
// Single-cycle ops are computed straight from the request on the accepting
// edge; MUL operands are captured by the multiplier on that same edge, so
// input changes after acceptance have no effect.
module alu_risc_mc
  import alu_risc_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int OPCODE_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_SIZE-1:0] select,
  input  logic [DATAWIDTH-1:0]   data_1,
  input  logic [DATAWIDTH-1:0]   data_2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATAWIDTH-1:0]   alu_out,
  output logic                   alu_zero_flag,
  output logic                   alu_carry_flag,
  output logic                   alu_neg_flag,
  output logic                   alu_ovf_flag,
  output logic [1:0]             dbg_state
);

  localparam int W = DATAWIDTH;

  state_e         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           carry_q, carry_d;
  logic           ovf_q, ovf_d;

  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic [2*W-1:0] mul_product;

  // Combinational single-cycle ALU on the incoming request.
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W-1:0]   alu_res;
  logic           alu_carry;
  logic           alu_ovf;

  always_comb begin
    sum       = {1'b0, data_1} + {1'b0, data_2};
    diff      = {1'b0, data_1} - {1'b0, data_2};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (select)
      OPCODE_SIZE'(OP_ADD): begin
        alu_res   = sum[W-1:0];
        alu_carry = sum[W];
        alu_ovf   = (data_1[W-1] == data_2[W-1]) && (sum[W-1] != data_1[W-1]);
      end
      OPCODE_SIZE'(OP_SUB): begin
        alu_res   = diff[W-1:0];
        alu_carry = diff[W];  // borrow: A < B unsigned
        alu_ovf   = (data_1[W-1] != data_2[W-1]) && (diff[W-1] != data_1[W-1]);
      end
      OPCODE_SIZE'(OP_AND): alu_res = data_1 & data_2;
      OPCODE_SIZE'(OP_NOT): alu_res = ~data_2;
      OPCODE_SIZE'(OP_OR):  alu_res = data_1 | data_2;
      OPCODE_SIZE'(OP_XOR): alu_res = data_1 ^ data_2;
      OPCODE_SIZE'(OP_SHL): begin
        alu_res   = data_1 << 1;
        alu_carry = data_1[W-1];
      end
      OPCODE_SIZE'(OP_SHR): begin
        alu_res   = data_1 >> 1;
        alu_carry = data_1[0];
      end
      // NOP and the codes owned by the control unit produce 0 with no flags.
      OPCODE_SIZE'(OP_NOP), OPCODE_SIZE'(OP_RD), OPCODE_SIZE'(OP_WR),
      OPCODE_SIZE'(OP_BR), OPCODE_SIZE'(OP_BRZ): alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  alu_risc_mul_seq #(.DATAWIDTH(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (data_1),
    .b       (data_2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (select == OPCODE_SIZE'(OP_MUL)) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            out_d   = alu_res;
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        // mul_busy is informational; completion is signalled by the done pulse.
        if (mul_done && !mul_busy) begin
          out_d   = mul_product[W-1:0];
          carry_d = |mul_product[2*W-1:W];
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready       = (state_q == ST_IDLE) && !rst;
  assign out_valid      = (state_q == ST_DONE);
  assign alu_out        = out_q;
  assign alu_zero_flag  = (out_q == '0);
  assign alu_neg_flag   = out_q[W-1];
  assign alu_carry_flag = carry_q;
  assign alu_ovf_flag   = ovf_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/alu_risc_mc.md
# alu_risc_mc

Multi-cycle, parametrised successor to the RISC datapath ALU. It adds registered results, a valid/ready handshake on both sides, an extended opcode set and full condition flags (zero, carry, negative, overflow). It also adds a sequential shift-add multiplier. The block sits between the register-file read stage and write-back, and the control unit stalls on `in_ready`/`out_valid`.

## Interface
- `DATAWIDTH`, 8: operand and result width; must be ≥ 2.
- `OPCODE_SIZE`, 4: select width; must be ≥ 4.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation request valid.
- `in_ready` output 1: block can accept a request.
- `select` input OPCODE_SIZE: opcode.
- `data_1` input DATAWIDTH: operand A.
- `data_2` input DATAWIDTH: operand B.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: consumer accepts the result.
- `alu_out` output DATAWIDTH: registered result.
- `alu_zero_flag` output 1: `alu_out == 0`.
- `alu_carry_flag` output 1: carry/borrow/shift-out/MUL high-half-nonzero.
- `alu_neg_flag` output 1: `alu_out[DATAWIDTH-1]`.
- `alu_ovf_flag` output 1: two's-complement overflow (ADD/SUB only, else 0).

## Operation
- Opcodes:
  - NOP=0000 → 0.
  - ADD=0001 → A+B.
  - SUB=0010 → A−B.
  - AND=0011 → A&B.
  - NOT=0100 → ~B.
  - OR=1001 → A|B.
  - XOR=1010 → A^B.
  - SHL=1011 → A<<1.
  - SHR=1100 → A>>1 (logical).
  - MUL=1101 → low DATAWIDTH bits of A*B, unsigned.
- Codes 0101–1000 are reserved for RD/WR/BR/BRZ; these and all other unlisted codes → result 0, all flags 0.
- Carry flag by opcode:
  - ADD: bit DATAWIDTH of the (DATAWIDTH+1)-bit sum.
  - SUB: borrow, i.e. A < B unsigned.
  - SHL: A[DATAWIDTH-1].
  - SHR: A[0].
  - MUL: 1 if the upper half of the 2·DATAWIDTH product is nonzero.
  - Others: 0.
- Overflow flag:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B signs differ and the result sign differs from A.
- The zero and negative flags are computed from the registered `alu_out` for every opcode.
- FSM states IDLE, MUL, DONE:
  - IDLE: `in_ready`=1. On `in_valid`, latch the operands and opcode. For MUL, go to MUL. For any other opcode, compute, register result and flags, and go to DONE.
  - MUL: one shift-add step per cycle, DATAWIDTH steps. After the last step, register result and flags and go to DONE. `in_ready`=0.
  - DONE: `out_valid`=1, outputs held stable. On `out_ready`, go to IDLE. `in_ready`=0, so there is no overlapping acceptance.
- Operand changes while not in IDLE are ignored; latched copies are used.

## Timing
- Reset values: state IDLE, `alu_out`=0, `out_valid`=0, all registered flags 0, `alu_zero_flag`=1 (since `alu_out`=0), `in_ready`=0 while `rst` is high, then 1.
- Single-cycle ops: accepted at edge k → `out_valid` high after edge k (latency 1).
- MUL: accepted at edge k → `out_valid` high after edge k+DATAWIDTH (latency DATAWIDTH+1).
- Handshake completes on a cycle where `out_valid && out_ready`; `in_ready` rises the following cycle. Minimum issue interval is 2 cycles for single-cycle ops and DATAWIDTH+2 cycles for MUL.
- `out_ready` held high continuously still yields a one-cycle `out_valid` pulse per operation.
- `rst` asserted in any state, including mid-MUL, aborts at the next edge and returns the block to reset values. The partial product is discarded.
- `in_valid` while `in_ready`=0 is ignored; the requester must hold the request.

## Structure
- Package `alu_risc_pkg`: opcode localparams (including the reserved RD/WR/BR/BRZ codes) and the FSM state encoding.
- Sub-module `alu_risc_mul_seq`: shift-add multiplier.
  - Ports: `start`, operands, `busy`, `done`, 2·DATAWIDTH product.
  - Synchronous reset.
- The top level holds the FSM, the operand latch, the combinational single-cycle ALU, and the result/flag registers.

## Test plan
- Reset, then ADD 8'h7F+8'h01 with `out_ready`=1 → 1 cycle later `alu_out`=8'h80, neg=1, ovf=1, carry=0, zero=0.
- SUB 8'h05−8'h05 → `alu_out`=0, zero=1, carry=0. SUB 8'h03−8'h05 → `alu_out`=8'hFE, carry=1, neg=1.
- MUL 8'h0F*8'h11 → `out_valid` 9 cycles after accept, `alu_out`=8'hFF, carry=0. MUL 8'h10*8'h10 → `alu_out`=0, carry=1, zero=1.
- Backpressure: SHL 8'h81 with `out_ready`=0 for 5 cycles → `alu_out`=8'h02, carry=1, held stable, `in_ready`=0 throughout. Raise `out_ready` → `in_ready`=1 on the next cycle.
- `rst` pulsed 3 cycles into MUL → next cycle `out_valid`=0, `alu_out`=0, `in_ready`=1 after `rst` drops. No stale result ever appears.
- Reserved opcode 0110 and undefined opcode 1111 → `alu_out`=0, zero=1, all other flags 0, latency 1.
